// File: rtl/mac_row_ctrl_if.sv
// Bus bundle between mac_row_ctrl, the local weight/activation SRAM and the MAC row.
// The busy_cnt signal exists only when MAC_ROW_CTRL_PERF_EN is defined.
interface mac_row_ctrl_if #(
    parameter int unsigned bw      = 4,
    parameter int unsigned addr_bw = 10,
    parameter int unsigned len_bw  = 8
);
    logic               start;
    logic               ready;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] x_base;
    logic [len_bw-1:0]  x_len;
    logic               mem_cen;
    logic [addr_bw-1:0] mem_addr;
    logic [bw-1:0]      mem_dout;
    logic [bw-1:0]      in_w;
    logic [1:0]         inst_w;
    logic               row_valid;
    logic               done;
    logic [len_bw-1:0]  out_cnt;
`ifdef MAC_ROW_CTRL_PERF_EN
    logic [31:0]        busy_cnt;
`endif

    // Controller side
    modport master (
        input  start, w_base, x_base, x_len, mem_dout, row_valid,
        output ready, mem_cen, mem_addr, in_w, inst_w, done, out_cnt
`ifdef MAC_ROW_CTRL_PERF_EN
        , output busy_cnt
`endif
    );

    // Job source / SRAM / row side
    modport slave (
        output start, w_base, x_base, x_len, mem_dout, row_valid,
        input  ready, mem_cen, mem_addr, in_w, inst_w, done, out_cnt
`ifdef MAC_ROW_CTRL_PERF_EN
        , input busy_cnt
`endif
    );
endinterface

// File: rtl/mac_row_ctrl.sv
// MAC row sequencer: streams col weights (kernel load), then x_len activations (execute),
// waits for x_len row outputs and pulses done. MAC_ROW_CTRL_PERF_EN adds busy_cnt.
module mac_row_ctrl #(
    parameter int unsigned bw      = 4,
    parameter int unsigned col     = 8,
    parameter int unsigned addr_bw = 10,
    parameter int unsigned len_bw  = 8
) (
    input  logic           clk,
    input  logic           reset,
    mac_row_ctrl_if.master bus
);
    localparam int unsigned CNT_W = (col > 1) ? $clog2(col) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_mem_cen;
    logic               r_done;
    logic [addr_bw-1:0] r_mem_addr;
    logic [addr_bw-1:0] r_x_base;
    logic [len_bw-1:0]  r_x_len;
    logic [len_bw-1:0]  r_j;
    logic [len_bw-1:0]  r_out_cnt;
    logic [CNT_W-1:0]   r_k;
    logic [1:0]         r_issue;
    logic [1:0]         r_inst;
    logic [bw-1:0]      w_in_w;
    logic               w_accept;
    logic               w_count;

    assign w_accept = bus.start & r_ready;
    assign w_count  = bus.row_valid
                    & ((r_state == S_EXEC) | (r_state == S_DRAIN))
                    & (r_out_cnt != r_x_len);
    assign w_in_w   = bus.mem_dout;

    // Sequencer FSM with registered SRAM/issue outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_mem_cen  <= 1'b1;
            r_done     <= 1'b0;
            r_mem_addr <= '0;
            r_x_base   <= '0;
            r_x_len    <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_issue    <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_LOAD;
                        r_ready    <= 1'b0;
                        r_mem_cen  <= 1'b0;
                        r_mem_addr <= bus.w_base;
                        r_x_base   <= bus.x_base;
                        r_x_len    <= bus.x_len;
                        r_k        <= '0;
                        r_issue    <= 2'b01;
                    end
                end
                S_LOAD: begin
                    if (r_k == CNT_W'(col - 1)) begin
                        if (r_x_len != '0) begin
                            r_state    <= S_EXEC;
                            r_mem_addr <= r_x_base;
                            r_j        <= '0;
                            r_issue    <= 2'b10;
                        end else begin
                            r_state   <= S_DRAIN;
                            r_mem_cen <= 1'b1;
                            r_issue   <= 2'b00;
                        end
                    end else begin
                        r_k        <= r_k + CNT_W'(1);
                        r_mem_addr <= r_mem_addr + addr_bw'(1);
                    end
                end
                S_EXEC: begin
                    if (r_j == r_x_len - len_bw'(1)) begin
                        r_state   <= S_DRAIN;
                        r_mem_cen <= 1'b1;
                        r_issue   <= 2'b00;
                    end else begin
                        r_j        <= r_j + len_bw'(1);
                        r_mem_addr <= r_mem_addr + addr_bw'(1);
                    end
                end
                S_DRAIN: begin
                    // Issue stage feeding inst_w is empty and every expected output has arrived
                    if ((r_out_cnt == r_x_len) && (r_issue == 2'b00)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_ready   <= 1'b1;
                    r_mem_cen <= 1'b1;
                    r_done    <= 1'b0;
                    r_issue   <= 2'b00;
                end
            endcase
        end
    end

    // Aligns the instruction with the SRAM read data reaching the row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_inst <= 2'b00;
        else        r_inst <= r_issue;
    end

    // Saturating count of east-most valid cycles for the current job
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_out_cnt <= '0;
        else if (w_accept) r_out_cnt <= '0;
        else if (w_count)  r_out_cnt <= r_out_cnt + len_bw'(1);
    end

`ifdef MAC_ROW_CTRL_PERF_EN
    logic [31:0] r_busy_cnt;

    // Cycles spent in LOAD, EXEC or DRAIN for the current job
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_busy_cnt <= '0;
        else if (w_accept)
            r_busy_cnt <= '0;
        else if ((r_state == S_LOAD) || (r_state == S_EXEC) || (r_state == S_DRAIN))
            r_busy_cnt <= r_busy_cnt + 32'd1;
    end

    assign bus.busy_cnt = r_busy_cnt;
`endif

    assign bus.ready    = r_ready;
    assign bus.mem_cen  = r_mem_cen;
    assign bus.mem_addr = r_mem_addr;
    assign bus.in_w     = w_in_w;
    assign bus.inst_w   = r_inst;
    assign bus.done     = r_done;
    assign bus.out_cnt  = r_out_cnt;
endmodule

// File: tb/tb_mac_row_ctrl.sv
// Directed self-checking bench for mac_row_ctrl with a behavioural SRAM and driven row_valid.
module tb_mac_row_ctrl;
    localparam int unsigned BW  = 4;
    localparam int unsigned COL = 8;
    localparam int unsigned ABW = 10;
    localparam int unsigned LBW = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    mac_row_ctrl_if #(.bw(BW), .addr_bw(ABW), .len_bw(LBW)) bus ();

    mac_row_ctrl #(.bw(BW), .col(COL), .addr_bw(ABW), .len_bw(LBW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [BW-1:0] mdata(input logic [ABW-1:0] a);
        return BW'(a[3:0] ^ a[7:4] ^ 4'hA);
    endfunction

    // SRAM model: one-cycle read latency
    always @(posedge clk) if (!bus.mem_cen) bus.mem_dout <= mdata(bus.mem_addr);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; bus.start = 1'b0; bus.row_valid = 1'b0;
        bus.w_base = '0; bus.x_base = '0; bus.x_len = '0;
        #2 reset = 1'b0;
        #10;
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ready); else n_pass++;
        n_checks++; if (bus.mem_cen !== 1'b1) $display("FAIL reset_cen: got %b want 1", bus.mem_cen); else n_pass++;
        n_checks++; if (bus.mem_addr !== 10'h000) $display("FAIL reset_addr: got %h want 000", bus.mem_addr); else n_pass++;
        n_checks++; if (bus.inst_w !== 2'b00) $display("FAIL reset_inst: got %b want 00", bus.inst_w); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.out_cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", bus.out_cnt); else n_pass++;
        @(negedge clk) reset = 1'b1;
        tick;
        n_checks++; if ({bus.ready, bus.mem_cen} !== 2'b11) $display("FAIL idle_hold: got %b want 11", {bus.ready, bus.mem_cen}); else n_pass++;
    endtask

    task automatic test_basic;
        logic [ABW-1:0] ea, pa;
        logic [1:0]     pi;
        int done_at, done_n;
        pa = '0; pi = 2'b00; done_at = -1; done_n = 0;
        bus.w_base = 10'h010; bus.x_base = 10'h100; bus.x_len = 8'd4; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            ea = (i < 8) ? ABW'(32'h010 + i) : ABW'(32'h100 + i - 8);
            n_checks++; if (bus.mem_cen !== ((i < 12) ? 1'b0 : 1'b1)) $display("FAIL basic_cen[%0d]: got %b", i, bus.mem_cen); else n_pass++;
            if (i < 12) begin
                n_checks++; if (bus.mem_addr !== ea) $display("FAIL basic_addr[%0d]: got %h want %h", i, bus.mem_addr, ea); else n_pass++;
            end
            if (i >= 1) begin
                n_checks++;
                if ({bus.inst_w, bus.in_w} !== {pi, mdata(pa)})
                    $display("FAIL basic_row[%0d]: got inst %b data %h want inst %b data %h", i, bus.inst_w, bus.in_w, pi, mdata(pa));
                else n_pass++;
            end
            pa = ea;
            pi = (i < 8) ? 2'b01 : 2'b10;
            if (i == 12) bus.row_valid = 1'b1;
            tick;
        end
        for (int c = 0; c < 40; c++) begin
            if (bus.done) begin done_n++; if (done_at < 0) done_at = 13 + c; end
            if (c == 3) bus.row_valid = 1'b0;
            tick;
        end
        n_checks++; if (done_n != 1) $display("FAIL basic_done_count: got %0d want 1", done_n); else n_pass++;
        n_checks++; if (done_at != 17) $display("FAIL basic_done_cycle: got %0d want 17", done_at); else n_pass++;
        n_checks++; if (bus.out_cnt !== 8'd4) $display("FAIL basic_out_cnt: got %0d want 4", bus.out_cnt); else n_pass++;
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL basic_ready_end: got %b want 1", bus.ready); else n_pass++;
    endtask

    task automatic test_zero_len;
        int reads, loads, execs, done_at, done_n;
        reads = 0; loads = 0; execs = 0; done_at = -1; done_n = 0;
        bus.w_base = 10'h200; bus.x_base = 10'h300; bus.x_len = 8'd0; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.mem_cen) reads++;
            if (bus.inst_w == 2'b01) loads++;
            if (bus.inst_w == 2'b10) execs++;
            if (bus.done) begin done_n++; if (done_at < 0) done_at = i; end
            tick;
        end
        n_checks++; if (reads != 8) $display("FAIL zero_reads: got %0d want 8", reads); else n_pass++;
        n_checks++; if (loads != 8) $display("FAIL zero_load_inst: got %0d want 8", loads); else n_pass++;
        n_checks++; if (execs != 0) $display("FAIL zero_exec_inst: got %0d want 0", execs); else n_pass++;
        n_checks++; if (done_at != 9) $display("FAIL zero_done_cycle: got %0d want 9", done_at); else n_pass++;
        n_checks++; if (done_n != 1) $display("FAIL zero_done_count: got %0d want 1", done_n); else n_pass++;
        n_checks++; if (bus.out_cnt !== 8'd0) $display("FAIL zero_out_cnt: got %0d want 0", bus.out_cnt); else n_pass++;
    endtask

    task automatic test_wrap;
        logic [ABW-1:0] ea;
        int done_n;
        done_n = 0;
        bus.w_base = 10'h3FC; bus.x_base = 10'h3FE; bus.x_len = 8'd4; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ea = (i < 8) ? ABW'(32'h3FC + i) : ABW'(32'h3FE + i - 8);
            n_checks++;
            if ({bus.mem_cen, bus.mem_addr} !== {1'b0, ea})
                $display("FAIL wrap_addr[%0d]: got cen %b addr %h want cen 0 addr %h", i, bus.mem_cen, bus.mem_addr, ea);
            else n_pass++;
            tick;
        end
        bus.row_valid = 1'b1;
        for (int c = 0; c < 4; c++) tick;
        bus.row_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done) done_n++;
            tick;
        end
        n_checks++; if (done_n != 1) $display("FAIL wrap_done_count: got %0d want 1", done_n); else n_pass++;
        n_checks++; if (bus.out_cnt !== 8'd4) $display("FAIL wrap_out_cnt: got %0d want 4", bus.out_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int ready_busy, done_at, done_n;
        ready_busy = 0; done_at = -1; done_n = 0;
        bus.w_base = 10'h020; bus.x_base = 10'h040; bus.x_len = 8'd4; bus.start = 1'b1;
        tick;
        for (int i = 0; i <= 30; i++) begin
            if (i <= 13 && bus.ready) ready_busy++;
            if (bus.done) begin done_n++; if (done_at < 0) done_at = i; end
            if (i == 14) begin
                n_checks++; if (bus.ready !== 1'b1) $display("FAIL b2b_ready_rise: got %b want 1", bus.ready); else n_pass++;
                n_checks++; if (bus.out_cnt !== 8'd4) $display("FAIL excess_out_cnt: got %0d want 4", bus.out_cnt); else n_pass++;
                bus.x_len = 8'd0;
            end
            if (i == 15) begin
                n_checks++;
                if ({bus.ready, bus.mem_cen, bus.mem_addr} !== {1'b0, 1'b0, 10'h020})
                    $display("FAIL b2b_reaccept: got ready %b cen %b addr %h want 0 0 020", bus.ready, bus.mem_cen, bus.mem_addr);
                else n_pass++;
                n_checks++; if (bus.out_cnt !== 8'd0) $display("FAIL b2b_cnt_clear: got %0d want 0", bus.out_cnt); else n_pass++;
                bus.start = 1'b0;
            end
            bus.row_valid = (i >= 8 && i <= 13);
            tick;
        end
        bus.row_valid = 1'b0;
        n_checks++; if (ready_busy != 0) $display("FAIL busy_ready: got %0d ready cycles want 0", ready_busy); else n_pass++;
        n_checks++; if (done_at != 13) $display("FAIL excess_done_cycle: got %0d want 13", done_at); else n_pass++;
        n_checks++; if (done_n != 2) $display("FAIL b2b_done_count: got %0d want 2", done_n); else n_pass++;
    endtask

    task automatic test_reset_mid_exec;
        int done_n;
        done_n = 0;
        bus.w_base = 10'h000; bus.x_base = 10'h080; bus.x_len = 8'd4; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        bus.row_valid = 1'b1;
        tick;
        bus.row_valid = 1'b0;
        n_checks++;
        if ({bus.mem_addr, bus.inst_w, bus.out_cnt} !== {10'h081, 2'b10, 8'd1})
            $display("FAIL pre_reset: got addr %h inst %b cnt %0d want 081 10 1", bus.mem_addr, bus.inst_w, bus.out_cnt);
        else n_pass++;
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.ready, bus.mem_cen, bus.inst_w, bus.out_cnt} !== {1'b1, 1'b1, 2'b00, 8'd0})
            $display("FAIL mid_reset: got ready %b cen %b inst %b cnt %0d want 1 1 00 0", bus.ready, bus.mem_cen, bus.inst_w, bus.out_cnt);
        else n_pass++;
        #2 reset = 1'b1;
        bus.w_base = 10'h030; bus.x_base = 10'h050; bus.x_len = 8'd2; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        n_checks++; if ({bus.mem_cen, bus.mem_addr} !== {1'b0, 10'h030}) $display("FAIL clean_first_addr: got cen %b addr %h want 0 030", bus.mem_cen, bus.mem_addr); else n_pass++;
        for (int i = 0; i < 8; i++) tick;
        n_checks++; if ({bus.mem_cen, bus.mem_addr} !== {1'b0, 10'h050}) $display("FAIL clean_exec_addr: got cen %b addr %h want 0 050", bus.mem_cen, bus.mem_addr); else n_pass++;
        bus.row_valid = 1'b1;
        tick; tick;
        bus.row_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done) done_n++;
            tick;
        end
        n_checks++; if (done_n != 1) $display("FAIL clean_done_count: got %0d want 1", done_n); else n_pass++;
        n_checks++; if (bus.out_cnt !== 8'd2) $display("FAIL clean_out_cnt: got %0d want 2", bus.out_cnt); else n_pass++;
    endtask

`ifdef MAC_ROW_CTRL_PERF_EN
    task automatic test_perf;
        logic [31:0] busy_at_done;
        int done_n;
        done_n = 0; busy_at_done = '0;
        bus.w_base = 10'h000; bus.x_base = 10'h100; bus.x_len = 8'd4; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i <= 30; i++) begin
            if (bus.done) begin done_n++; busy_at_done = bus.busy_cnt; end
            bus.row_valid = (i >= 10 && i <= 13);
            tick;
        end
        bus.row_valid = 1'b0;
        n_checks++; if (done_n != 1) $display("FAIL perf_done_count: got %0d want 1", done_n); else n_pass++;
        n_checks++; if (busy_at_done !== 32'd15) $display("FAIL perf_busy_at_done: got %0d want 15", busy_at_done); else n_pass++;
        n_checks++; if (bus.busy_cnt !== 32'd15) $display("FAIL perf_busy_hold: got %0d want 15", bus.busy_cnt); else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_zero_len;
        test_wrap;
        test_back_to_back;
        test_reset_mid_exec;
`ifdef MAC_ROW_CTRL_PERF_EN
        test_perf;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
